// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: req/ack data-memory access, lane steering and load extension.
// Optional misaligned-access trap when MEM_MISALIGN_TRAP_EN is defined.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_RegWrite,
    input  logic [4:0]  in_RegDest,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_RegDest,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [4:0]       r_rd;
    logic             r_regwrite;

    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    logic        to_hit;
    logic        is_mem;
    logic        misalign;

    assign stall  = (state == BUSY);
    assign is_mem = in_MemRead | in_MemWrite;
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign =
        ((in_funct3[1:0] == 2'b01) && alu_result[0]) ||
        (in_funct3[1] && (alu_result[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // funct3[1:0] picks the size; 1x codes all behave as a word
    always_comb begin
        st_strb = 4'b1111;
        st_data = store_data;
        case (in_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << alu_result[1:0];
                st_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb = alu_result[1] ? 4'b1100 : 4'b0011;
                st_data = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_b = mem_rdata[7:0];
        case (r_off)
            2'b00: ld_b = mem_rdata[7:0];
            2'b01: ld_b = mem_rdata[15:8];
            2'b10: ld_b = mem_rdata[23:16];
            2'b11: ld_b = mem_rdata[31:24];
            default: ;
        endcase
        ld_h = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        case (r_funct3[1:0])
            2'b00: ld_data = {{24{~r_funct3[2] & ld_b[7]}}, ld_b};
            2'b01: ld_data = {{16{~r_funct3[2] & ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_RegDest  <= '0;
            wb_data     <= '0;
            bus_err     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mem && misalign) begin
                            wb_valid    <= 1'b1;
                            wb_RegWrite <= 1'b0;
                            wb_RegDest  <= in_RegDest;
                            wb_data     <= '0;
                            bus_err     <= 1'b1;
                        end else if (is_mem) begin
                            mem_req    <= 1'b1;
                            mem_we     <= in_MemWrite;
                            mem_addr   <= {alu_result[31:2], 2'b00};
                            mem_wdata  <= in_MemWrite ? st_data : '0;
                            mem_wstrb  <= in_MemWrite ? st_strb : 4'b0000;
                            r_funct3   <= in_funct3;
                            r_off      <= alu_result[1:0];
                            r_rd       <= in_RegDest;
                            r_regwrite <= in_RegWrite;
                            cnt        <= '0;
                            state      <= BUSY;
                        end else begin
                            wb_valid    <= 1'b1;
                            wb_RegWrite <= in_RegWrite;
                            wb_RegDest  <= in_RegDest;
                            wb_data     <= alu_result;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // ack takes priority over a same-cycle timeout
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_RegDest <= r_rd;
                        if (mem_we) begin
                            wb_RegWrite <= 1'b0;
                            wb_data     <= '0;
                        end else begin
                            wb_RegWrite <= r_regwrite;
                            wb_data     <= ld_data;
                        end
                    end else if (to_hit) begin
                        mem_req     <= 1'b0;
                        state       <= IDLE;
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= 1'b0;
                        wb_RegDest  <= r_rd;
                        wb_data     <= '0;
                        bus_err     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage that consumes the execute stage's registered outputs: ALU result, store data, control flags and destination register.
- Runs a req/ack handshake with data memory for loads and stores, and does byte/halfword lane steering and load sign/zero extension.
- Stalls upstream while a memory access is outstanding.
- Delivers one registered writeback beat per instruction to the WB stage.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles waiting for mem_ack before the access is aborted; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  execute stage presents an instruction this cycle.
- in_MemRead  in  1  instruction is a load.
- in_MemWrite  in  1  instruction is a store.
- in_RegWrite  in  1  instruction writes rd.
- in_RegDest  in  5  destination register index.
- in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result  in  32  effective address for loads/stores, or writeback value otherwise.
- store_data  in  32  rs2 value for stores.
- stall  out  1  hold upstream inputs stable; equals (state==BUSY).
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables (0 for reads).
- mem_ack  in  1  memory completes the request this cycle; mem_rdata valid when mem_we=0.
- mem_rdata  in  32  read data word.
- wb_valid  out  1  one-cycle pulse, writeback beat valid.
- wb_RegWrite  out  1  write rd.
- wb_RegDest  out  5  rd index.
- wb_data  out  32  value to write.
- bus_err  out  1  one-cycle pulse on timeout or misalignment.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. Reset mid-access drops mem_req immediately and discards the access.
- FSM states: IDLE, BUSY.
- IDLE, in_valid=1, neither MemRead nor MemWrite:
  - Next edge: wb_valid=1, wb_data=alu_result, wb_RegWrite=in_RegWrite, wb_RegDest=in_RegDest.
  - Latency 1 cycle.
- IDLE, in_valid=1 with MemRead or MemWrite:
  - Next edge: register address, size, rd and RegWrite; set mem_req=1; enter BUSY.
  - mem_we=in_MemWrite; if both MemRead and MemWrite are set, the write wins.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable. in_valid is ignored; upstream holds its inputs because stall=1.
  - Counter increments each BUSY cycle.
  - mem_ack=1 sampled at an edge: mem_req=0, state goes to IDLE, wb_valid=1 that same edge.
  - Load beat: wb_RegWrite=registered RegWrite, wb_data=extended read data.
  - Store beat: wb_RegWrite=0.
  - Minimum load/store latency 2 edges (accept, ack). Back-to-back accepts are possible once stall drops.
- Timeout: TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ack:
  - Abort: mem_req=0, IDLE, wb_valid=1, wb_RegWrite=0, bus_err=1 for one cycle.
  - If ack and timeout occur on the same cycle, ack wins.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{sd[15:0]}}.
  - SW: wstrb=4'b1111, wdata=sd.
- Load extraction:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Any other funct3 is treated as W.
- wb_valid and bus_err are pulses, cleared on the following edge.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0]!=0, is not issued to memory: no mem_req.
  - Next edge: wb_valid=1, wb_RegWrite=0, bus_err=1.
- Undefined:
  - Misaligned low bits are ignored. H uses addr[1]; W uses the aligned word.
  - bus_err is driven only by timeout.

Test Plan:
- ALU passthrough: in_valid=1, MemRead=MemWrite=0, RegWrite=1, rd=5, alu_result=32'h1234 -> next edge wb_valid=1, wb_RegDest=5, wb_data=32'h1234, mem_req stays 0.
- Load byte sign-extend: LB addr=32'h103, ack after 3 cycles with rdata=32'h80FF_0000 -> mem_addr=32'h100, stall high 3 cycles, wb_data=32'hFFFF_FF80. Same access as LBU -> wb_data=32'h80.
- Store half: SH addr=32'h22, store_data=32'hAAAA_BEEF -> mem_we=1, mem_wstrb=4'b1100, mem_wdata=32'hBEEF_BEEF, mem_addr=32'h20; on ack, wb_valid=1, wb_RegWrite=0.
- Timeout: TIMEOUT_CYCLES=4, LW with no ack -> mem_req high exactly 4 cycles, then bus_err=1 and wb_valid=1 with wb_RegWrite=0, stall=0.
- Reset mid-access: assert rst while BUSY -> mem_req, stall and wb_valid go 0 asynchronously; after release, a new LW completes normally.
- Misalign (macro defined): LW addr=32'h102 -> no mem_req, next edge bus_err=1. Macro undefined: mem_addr=32'h100 and rdata is returned unmodified.
